// File: rtl/audio_delay_engine.sv
// Single-port SRAM delay/loop engine: bypass, feedback echo, loop record and loop play.
// Optional build macro DELAY_SAT_EN: clamp output/feedback sums and drive a sticky sat_flag.
module audio_delay_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int GAIN_W = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic [GAIN_W-1:0] fb_gain,
    input  logic [GAIN_W-1:0] mix_gain,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   loop_len,
    output logic              sat_flag
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int SUM_W  = DATA_W + 2;

    localparam logic [ADDR_W:0]   LOOP_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LOOP_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LOOP_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    localparam logic [1:0] MODE_BYP  = 2'b00;
    localparam logic [1:0] MODE_ECHO = 2'b01;
    localparam logic [1:0] MODE_REC  = 2'b10;
    localparam logic [1:0] MODE_PLAY = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CALC = 2'd2,
        WR   = 2'd3
    } state_t;

    // Signed tap times unsigned gain at full precision, then arithmetic shift back to sample scale.
    function automatic logic signed [SUM_W-1:0] scale_tap(input logic signed [DATA_W-1:0] tap,
                                                          input logic [GAIN_W-1:0] gain);
        logic signed [PROD_W-1:0] tap_x;
        logic signed [PROD_W-1:0] gain_x;
        logic signed [PROD_W-1:0] prod;
        tap_x  = PROD_W'(tap);
        gain_x = PROD_W'({1'b0, gain});
        prod   = tap_x * gain_x;
        return SUM_W'(prod >>> GAIN_W);
    endfunction

`ifdef DELAY_SAT_EN
    function automatic logic ovf(input logic signed [SUM_W-1:0] s);
        return !((&s[SUM_W-1:DATA_W-1]) || !(|s[SUM_W-1:DATA_W-1]));
    endfunction

    function automatic logic [DATA_W-1:0] fit(input logic signed [SUM_W-1:0] s);
        if (ovf(s)) begin
            if (s[SUM_W-1]) begin
                fit = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                fit = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            fit = s[DATA_W-1:0];
        end
    endfunction
`else
    function automatic logic [DATA_W-1:0] fit(input logic signed [SUM_W-1:0] s);
        return s[DATA_W-1:0];
    endfunction
`endif

    state_t                     state_r;
    logic [1:0]                 mode_r;
    logic [1:0]                 prev_mode_r;
    logic signed [DATA_W-1:0]   in_r;
    logic [GAIN_W-1:0]          fb_gain_r;
    logic [GAIN_W-1:0]          mix_gain_r;
    logic                       do_read_r;
    logic [ADDR_W-1:0]          wr_ptr_r;
    logic [ADDR_W-1:0]          play_ptr_r;

    logic                       enter_s;
    logic                       rd_en_s;
    logic [ADDR_W-1:0]          rd_addr_s;
    logic signed [DATA_W-1:0]   tap_s;
    logic signed [SUM_W-1:0]    wet_s;
    logic signed [SUM_W-1:0]    fbk_s;
    logic signed [SUM_W-1:0]    out_sum_s;
    logic signed [SUM_W-1:0]    fb_sum_s;
    logic [ADDR_W:0]            play_next_s;

    // Read strobe and address chosen at the handshake from the live mode and pointers.
    always_comb begin
        enter_s   = (mode != prev_mode_r);
        rd_en_s   = 1'b0;
        rd_addr_s = PTR_ZERO;
        case (mode)
            MODE_ECHO: begin
                rd_en_s   = 1'b1;
                rd_addr_s = wr_ptr_r - delay_len;
            end
            MODE_PLAY: begin
                rd_en_s = (loop_len != LOOP_ZERO);
                if (enter_s) begin
                    rd_addr_s = PTR_ZERO;
                end else begin
                    rd_addr_s = play_ptr_r;
                end
            end
            default: begin
                rd_en_s   = 1'b0;
                rd_addr_s = PTR_ZERO;
            end
        endcase
    end

    // Tap scaling and sums evaluated while the read data is on mem_rdata.
    always_comb begin
        if (do_read_r) begin
            tap_s = $signed(mem_rdata);
        end else begin
            tap_s = DATA_ZERO;
        end
        wet_s       = scale_tap(tap_s, mix_gain_r);
        fbk_s       = scale_tap(tap_s, fb_gain_r);
        out_sum_s   = SUM_W'(in_r) + wet_s;
        fb_sum_s    = SUM_W'(in_r) + fbk_s;
        play_next_s = {1'b0, play_ptr_r} + LOOP_ONE;
    end

`ifdef DELAY_SAT_EN
    logic sat_r;
    logic sat_hit_s;

    // Any clamp in a mode that produces sums raises the sticky flag.
    always_comb begin
        case (mode_r)
            MODE_ECHO: sat_hit_s = ovf(out_sum_s) || ovf(fb_sum_s);
            MODE_PLAY: sat_hit_s = ovf(out_sum_s);
            default:   sat_hit_s = 1'b0;
        endcase
    end

    // Sticky saturation flag, cleared only by reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sat_r <= 1'b0;
        end else if (state_r == CALC && sat_hit_s) begin
            sat_r <= 1'b1;
        end
    end

    assign sat_flag = sat_r;
`else
    assign sat_flag = 1'b0;
`endif

    // Four-phase sample FSM with registered handshake, result and SRAM strobes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r     <= IDLE;
            mode_r      <= MODE_BYP;
            prev_mode_r <= MODE_BYP;
            in_r        <= DATA_ZERO;
            fb_gain_r   <= {GAIN_W{1'b0}};
            mix_gain_r  <= {GAIN_W{1'b0}};
            do_read_r   <= 1'b0;
            wr_ptr_r    <= PTR_ZERO;
            play_ptr_r  <= PTR_ZERO;
            loop_len    <= LOOP_ZERO;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= DATA_ZERO;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= PTR_ZERO;
            mem_wdata   <= DATA_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mode_r      <= mode;
                        prev_mode_r <= mode;
                        in_r        <= in_data;
                        fb_gain_r   <= fb_gain;
                        mix_gain_r  <= mix_gain;
                        do_read_r   <= rd_en_s;
                        if (enter_s && mode == MODE_REC) begin
                            loop_len <= LOOP_ZERO;
                        end
                        if (enter_s && mode == MODE_PLAY) begin
                            play_ptr_r <= PTR_ZERO;
                        end
                        mem_en   <= rd_en_s;
                        mem_we   <= 1'b0;
                        mem_addr <= rd_addr_s;
                        in_ready <= 1'b0;
                        state_r  <= RD;
                    end
                end
                RD: begin
                    mem_en  <= 1'b0;
                    state_r <= CALC;
                end
                CALC: begin
                    out_valid <= 1'b1;
                    state_r   <= WR;
                    case (mode_r)
                        MODE_ECHO: begin
                            out_data  <= fit(out_sum_s);
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_ptr_r;
                            mem_wdata <= fit(fb_sum_s);
                        end
                        MODE_REC: begin
                            out_data <= in_r;
                            // A full buffer keeps its contents; the sample only passes through.
                            if (loop_len != LOOP_FULL) begin
                                mem_en    <= 1'b1;
                                mem_we    <= 1'b1;
                                mem_addr  <= loop_len[ADDR_W-1:0];
                                mem_wdata <= in_r;
                            end
                        end
                        MODE_PLAY: begin
                            out_data <= fit(out_sum_s);
                        end
                        default: begin
                            out_data <= in_r;
                        end
                    endcase
                end
                WR: begin
                    out_valid <= 1'b0;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= IDLE;
                    case (mode_r)
                        MODE_ECHO: begin
                            wr_ptr_r <= wr_ptr_r + PTR_ONE;
                        end
                        MODE_REC: begin
                            if (loop_len != LOOP_FULL) begin
                                loop_len <= loop_len + LOOP_ONE;
                            end
                        end
                        MODE_PLAY: begin
                            if (loop_len != LOOP_ZERO) begin
                                if (play_next_s == loop_len) begin
                                    play_ptr_r <= PTR_ZERO;
                                end else begin
                                    play_ptr_r <= play_next_s[ADDR_W-1:0];
                                end
                            end
                        end
                        default: begin
                            wr_ptr_r <= wr_ptr_r;
                        end
                    endcase
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_delay_engine.sv
// Scoreboard bench for audio_delay_engine with a 16-entry SRAM model (DATA_W=16, ADDR_W=4, GAIN_W=8).
module tb_audio_delay_engine;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic [AW-1:0] delay_len = '0;
    logic [GW-1:0] fb_gain = '0;
    logic [GW-1:0] mix_gain = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [AW:0]   loop_len;
    logic          sat_flag;

    audio_delay_engine #(.DATA_W(DW), .ADDR_W(AW), .GAIN_W(GW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .mode     (mode),
        .delay_len(delay_len),
        .fb_gain  (fb_gain),
        .mix_gain (mix_gain),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .loop_len (loop_len),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    // SRAM model with clear/preload hooks for the bench.
    logic [DW-1:0] mem [16];
    logic          mem_clear = 1'b0;
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    int            mem_en_cnt = 0;
    int            wr_cnt = 0;
    int            cyc = 0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) mem_en_cnt <= mem_en_cnt + 1;
        if (mem_en && mem_we) wr_cnt <= wr_cnt + 1;
    end

    typedef struct {
        logic [DW-1:0] data;
        int            hs;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: the result is consumed at the edge closing its WR cycle, three edges after the handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_out: got out_valid with data %0d expected none", out_data);
                end else begin
                    e = q.pop_front();
                    chk("out_data", int'(out_data), int'(e.data));
                    chk("latency", cyc + 1 - e.hs, 3);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [1:0] m, input logic [DW-1:0] d, input logic [DW-1:0] exp_d);
        exp_t e;
        wait_ready();
        mode     = m;
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.data = exp_d;
        e.hs   = cyc;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((!in_ready || q.size() != 0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready || q.size() != 0) chk("idle_timeout", 0, 1);
    endtask

    task automatic reset_all();
        in_valid  = 1'b0;
        rst       = 1'b1;
        mem_clear = 1'b1;
        @(posedge clk);
        #1;
        mem_clear = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    int echo_in  [10] = '{1000, 0, 0, 0, 0, 0, -401, 0, 0, 0};
    int echo_exp [10] = '{1000, 0, 0, 500, 0, 0, -401, 0, 0, -201};
    int play_exp [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};

    initial begin
        int en0;
        int wc0;
        int k;

        // Reset state
        reset_all();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_loop_len", loop_len, 0);
        chk("rst_sat_flag", sat_flag, 0);

        // Bypass: passthrough, no SRAM traffic
        mix_gain = 8'd128;
        fb_gain  = 8'd64;
        en0 = mem_en_cnt;
        send(2'b00, 16'h1234, 16'h1234);
        send(2'b00, 16'h8001, 16'h8001);
        wait_idle();
        chk("bypass_mem_en", mem_en_cnt - en0, 0);

        // Echo impulse, delay 3, half wet, with a negative tap rounding toward -inf
        reset_all();
        delay_len = 4'd3;
        mix_gain  = 8'd128;
        fb_gain   = 8'd0;
        for (int i = 0; i < 10; i++) send(2'b01, 16'(echo_in[i]), 16'(echo_exp[i]));
        wait_idle();

        // Echo at full depth with feedback
        reset_all();
        delay_len = 4'd0;
        mix_gain  = 8'd255;
        fb_gain   = 8'd128;
        for (int i = 0; i <= 32; i++) begin
            send(2'b01, (i == 0) ? 16'd1000 : 16'd0,
                 (i == 0) ? 16'd1000 : (i == 16) ? 16'd996 : (i == 32) ? 16'd498 : 16'd0);
            if (i == 0) begin
                wait_idle();
                chk("full_first_write", mem[0], 1000);
            end
            if (i == 16) begin
                wait_idle();
                chk("full_wrap_write", mem[0], 500);
            end
        end
        wait_idle();

        // Loop record 1..5 then play
        reset_all();
        mix_gain = 8'd255;
        fb_gain  = 8'd0;
        for (int i = 1; i <= 5; i++) send(2'b10, 16'(i), 16'(i));
        wait_idle();
        chk("rec_loop_len", loop_len, 5);
        for (int i = 0; i < 10; i++) send(2'b11, 16'd0, 16'(play_exp[i]));
        wait_idle();
        chk("play_loop_len", loop_len, 5);

        // Record overflow: length saturates, buffer not overwritten
        wc0 = wr_cnt;
        for (int i = 0; i < 20; i++) send(2'b10, 16'(101 + i), 16'(101 + i));
        wait_idle();
        chk("rec_full_len", loop_len, 16);
        chk("rec_full_writes", wr_cnt - wc0, 16);
        chk("rec_full_mem0", mem[0], 101);
        chk("rec_full_mem15", mem[15], 116);

        // Saturation on echo sum
        reset_all();
        pre_addr = 4'd15;
        pre_data = 16'h7FFF;
        pre_en   = 1'b1;
        @(posedge clk);
        #1;
        pre_en    = 1'b0;
        delay_len = 4'd1;
        mix_gain  = 8'd255;
        fb_gain   = 8'd0;
`ifdef DELAY_SAT_EN
        send(2'b01, 16'h7FFF, 16'h7FFF);
        wait_idle();
        chk("sat_flag", sat_flag, 1);
`else
        send(2'b01, 16'h7FFF, 16'hFF7E);
        wait_idle();
        chk("sat_flag", sat_flag, 0);
`endif
        chk("sat_fb_write", mem[0], 32767);

        // Reset while a record write is in WR
        reset_all();
        send(2'b10, 16'd11, 16'd11);
        send(2'b10, 16'd22, 16'd22);
        wait_idle();
        chk("pre_rst_loop_len", loop_len, 2);
        mode     = 2'b10;
        in_data  = 16'd33;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (!mem_we && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("reach_wr", mem_we, 1);
        rst = 1'b1;
        #1;
        chk("rst_wr_mem_en", mem_en, 0);
        chk("rst_wr_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_wr_in_ready", in_ready, 1);
        chk("rst_wr_loop_len", loop_len, 0);
        chk("rst_wr_no_commit", mem[2], 0);

        repeat (6) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
